// File: rtl/operand_fwd_ctrl.sv
// operand_fwd_ctrl: load-use stall and ALU operand forwarding selects; FWD_PERF_CNT_EN adds perf counters
module operand_fwd_ctrl #(
    parameter int REG_ADDR_W = 4
`ifdef FWD_PERF_CNT_EN
    , parameter int CNT_W = 16
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ext_stall,
    input  logic                  flush,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_we,
    input  logic                  id_is_load,
    output logic                  stall_out,
    output logic                  ex_valid,
    output logic [1:0]            sel_a,
    output logic [1:0]            sel_b
`ifdef FWD_PERF_CNT_EN
    , output logic [CNT_W-1:0]    stall_cnt,
    output logic [CNT_W-1:0]      fwd_cnt_a,
    output logic [CNT_W-1:0]      fwd_cnt_b
`endif
);
    // The RET stage needs no storage: a WB producer matched at ID is in RET when the consumer reaches EX.
    logic                  ex_we, ex_is_load, mem_valid, mem_we, wb_valid, wb_we;
    logic [REG_ADDR_W-1:0] ex_rd, mem_rd, wb_rd;
    logic                  ex_prod, mem_prod, wb_prod, take;
    logic [1:0]            sel_a_nx, sel_b_nx;

    function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] rs);
        return (rs == '0)                  ? 2'b00 :
               (ex_prod  && ex_rd  == rs)  ? 2'b01 :
               (mem_prod && mem_rd == rs)  ? 2'b10 :
               (wb_prod  && wb_rd  == rs)  ? 2'b11 : 2'b00;
    endfunction

    assign ex_prod  = ex_valid  && ex_we  && (ex_rd  != '0);
    assign mem_prod = mem_valid && mem_we && (mem_rd != '0);
    assign wb_prod  = wb_valid  && wb_we  && (wb_rd  != '0);

    // Load-use hazard: the EX load's result is not ready for an ID consumer.
    always_comb begin
        stall_out = id_valid && ex_prod && ex_is_load && (id_rs1 == ex_rd || id_rs2 == ex_rd);
        take      = id_valid && !flush && !stall_out;
        sel_a_nx  = take ? fwd_sel(id_rs1) : 2'b00;
        sel_b_nx  = take ? fwd_sel(id_rs2) : 2'b00;
    end

    // Pipeline tag shift; EX takes the ID instruction or a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid   <= 1'b0;
            ex_we      <= 1'b0;
            ex_is_load <= 1'b0;
            ex_rd      <= '0;
            mem_valid  <= 1'b0;
            mem_we     <= 1'b0;
            mem_rd     <= '0;
            wb_valid   <= 1'b0;
            wb_we      <= 1'b0;
            wb_rd      <= '0;
            sel_a      <= 2'b00;
            sel_b      <= 2'b00;
        end else if (!ext_stall) begin
            wb_valid   <= mem_valid;
            wb_we      <= mem_we;
            wb_rd      <= mem_rd;
            mem_valid  <= ex_valid;
            mem_we     <= ex_we;
            mem_rd     <= ex_rd;
            ex_valid   <= take;
            ex_we      <= take && id_we;
            ex_is_load <= take && id_is_load;
            ex_rd      <= id_rd;
            sel_a      <= sel_a_nx;
            sel_b      <= sel_b_nx;
        end
    end

`ifdef FWD_PERF_CNT_EN
    // Saturating counters of stall cycles and forwarded operands, frozen with the pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            fwd_cnt_a <= '0;
            fwd_cnt_b <= '0;
        end else if (!ext_stall) begin
            if (stall_out && !(&stall_cnt)) stall_cnt <= stall_cnt + CNT_W'(1);
            if (sel_a_nx != 2'b00 && !(&fwd_cnt_a)) fwd_cnt_a <= fwd_cnt_a + CNT_W'(1);
            if (sel_b_nx != 2'b00 && !(&fwd_cnt_b)) fwd_cnt_b <= fwd_cnt_b + CNT_W'(1);
        end
    end
`endif
endmodule
